sw_key_peripheral: RTL and testbench

SW_KEY_PERIPHERAL -- requirements
Module: sw_key_peripheral

---
 rtl/sw_key_pkg.sv | 15 +
 rtl/key_debouncer.sv | 32 +++
 rtl/sw_key_peripheral.sv | 98 +++++++++
 tb/tb_sw_key_peripheral.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sw_key_pkg.sv
// Shared constants for the slide-switch / pushbutton register peripheral.
// Latency: n/a (constants only); backpressure: n/a.
package sw_key_pkg;

    localparam int NUM_SW  = 10;
    localparam int NUM_KEY = 4;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 2;

    localparam logic [ADDR_W-1:0] ADDR_SW   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_KEY  = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd3;

endpackage

// File: rtl/key_debouncer.sv
// Single-key debouncer: accepts a new level after DEBOUNCE_CYCLES consecutive disagreeing samples.
// Latency: DEBOUNCE_CYCLES cycles from a settled input to the stable output; backpressure: none.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic sync,
    output logic stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Any agreeing sample restarts the run, so a glitch can never accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sw_key_peripheral.sv
// Memory-mapped switch/key peripheral: synchronized switches, debounced keys, W1C edge capture, masked irq.
// Latency: reads return one cycle after the strobe; backpressure: none, every access is accepted.
module sw_key_peripheral
    import sw_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  sw_in,
    input  logic [3:0]  key_n_in,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        irq
);

    logic [NUM_SW-1:0]  sw_s1, sw_s2;
    logic [NUM_KEY-1:0] key_s1, key_s2;
    logic [1:0]         sync_fill;
    logic [NUM_KEY-1:0] key_sync, key_stable, key_prev;
    logic [NUM_KEY-1:0] edge_reg, mask_reg, edge_set, edge_clr;
    logic [DATA_W-1:0]  rd_mux;
    logic               unused_wd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1     <= '0;
            sw_s2     <= '0;
            key_s1    <= '0;
            key_s2    <= '0;
            sync_fill <= '0;
        end else begin
            sw_s1     <= sw_in;
            sw_s2     <= sw_s1;
            key_s1    <= key_n_in;
            key_s2    <= key_s1;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // The cleared synchronizer reads as "all pressed" once inverted, so keys are
    // presented as released until both stages hold real samples.
    assign key_sync = ~key_s2 & {NUM_KEY{sync_fill[1]}};

    for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk    (clk),
            .rst    (rst),
            .sync   (key_sync[i]),
            .stable (key_stable[i])
        );
    end

    assign edge_set  = key_stable & ~key_prev;
    assign edge_clr  = (write && address == ADDR_EDGE) ? writedata[NUM_KEY-1:0] : '0;
    assign unused_wd = ^writedata[DATA_W-1:NUM_KEY];

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_SW:   rd_mux = DATA_W'(sw_s2);
            ADDR_KEY:  rd_mux = DATA_W'(key_stable);
            ADDR_EDGE: rd_mux = DATA_W'(edge_reg);
            ADDR_MASK: rd_mux = DATA_W'(mask_reg);
            default:   rd_mux = '0;
        endcase
    end

    // Read mux samples pre-write state, so a same-cycle write is not visible until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_prev      <= '0;
            edge_reg      <= '0;
            mask_reg      <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
            irq           <= 1'b0;
        end else begin
            key_prev      <= key_stable;
            edge_reg      <= (edge_reg & ~edge_clr) | edge_set;
            readdatavalid <= read;
            irq           <= |(edge_reg & mask_reg);
            if (write && address == ADDR_MASK) begin
                mask_reg <= writedata[NUM_KEY-1:0];
            end
            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_sw_key_peripheral.sv
// Bench for sw_key_peripheral: directed scenarios then random traffic, all scored against a behavioural model.
module tb_sw_key_peripheral;
    import sw_key_pkg::*;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  sw_in = '0;
    logic [3:0]  key_n_in = 4'hF;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        irq;

    sw_key_peripheral #(.DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .sw_in         (sw_in),
        .key_n_in      (key_n_in),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: raw input samples taken at each edge since reset, and the
    // pressed-level history the debouncers have seen.
    logic [9:0]  raw_sw  [$];
    logic [3:0]  raw_key [$];
    logic [3:0]  seen    [$];
    logic [3:0]  m_stable, m_was, m_edge, m_mask;
    logic [31:0] m_rdata;
    logic        m_rdv, m_irq;

    task automatic model_reset();
        raw_sw.delete();
        raw_key.delete();
        seen.delete();
        m_stable = '0;
        m_was    = '0;
        m_edge   = '0;
        m_mask   = '0;
        m_rdata  = '0;
        m_rdv    = 1'b0;
        m_irq    = 1'b0;
    endtask

    // One clock edge: a key flips once its synchronized level has disagreed with
    // the accepted level for D edges in a row; synchronized data is the raw sample
    // from two edges back (released/zero until two edges have passed).
    task automatic model_step(input logic [9:0] sw, input logic [3:0] kn, input logic [1:0] a,
                              input logic rd, input logic wr, input logic [31:0] wd);
        logic [9:0] sw_sync;
        logic [3:0] key_sync, nstable, clr;
        int n;
        bit all_diff;
        n        = raw_sw.size();
        sw_sync  = (n >= 2) ? raw_sw[n-2] : 10'h0;
        key_sync = (n >= 2) ? ~raw_key[n-2] : 4'h0;
        m_rdv = rd;
        if (rd) begin
            case (a)
                ADDR_SW:   m_rdata = {22'h0, sw_sync};
                ADDR_KEY:  m_rdata = {28'h0, m_stable};
                ADDR_EDGE: m_rdata = {28'h0, m_edge};
                default:   m_rdata = {28'h0, m_mask};
            endcase
        end
        m_irq = |(m_edge & m_mask);
        seen.push_back(key_sync);
        if (seen.size() > D) void'(seen.pop_front());
        nstable = m_stable;
        if (seen.size() == D) begin
            for (int k = 0; k < 4; k++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) if (seen[j][k] == m_stable[k]) all_diff = 1'b0;
                if (all_diff) nstable[k] = ~m_stable[k];
            end
        end
        clr = (wr && a == ADDR_EDGE) ? wd[3:0] : 4'h0;
        // A key newly accepted as pressed on the previous edge is captured now; capture beats a clear.
        m_edge = (m_edge & ~clr) | (m_stable & ~m_was);
        if (wr && a == ADDR_MASK) m_mask = wd[3:0];
        m_was    = m_stable;
        m_stable = nstable;
        raw_sw.push_back(sw);
        raw_key.push_back(kn);
        if (raw_sw.size() > 3) begin
            void'(raw_sw.pop_front());
            void'(raw_key.pop_front());
        end
    endtask

    task automatic cycle(input logic [1:0] a, input logic rd, input logic wr, input logic [31:0] wd);
        address   = a;
        read      = rd;
        write     = wr;
        writedata = wd;
        model_step(sw_in, key_n_in, a, rd, wr, wd);
        @(negedge clk);
        chk("rdv",   {31'h0, readdatavalid}, {31'h0, m_rdv});
        chk("rdata", readdata, m_rdata);
        chk("irq",   {31'h0, irq}, {31'h0, m_irq});
        address   = '0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(2'd0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_rdata", readdata, 32'h0);
        chk("rst_rdv", {31'h0, readdatavalid}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        sw_in = 10'h2A5;
        model_reset();
        @(negedge clk);
        do_reset();

        // Switch readback after reset release
        idle(4);
        cycle(ADDR_SW, 1'b1, 1'b0, 32'h0);
        chk("sw_word", readdata, 32'h2A5);
        chk("sw_rdv", {31'h0, readdatavalid}, 32'h1);
        idle(1);
        chk("sw_rdv_drop", {31'h0, readdatavalid}, 32'h0);

        // Glitch shorter than the debounce window is ignored
        cycle(ADDR_MASK, 1'b0, 1'b1, 32'h2);
        key_n_in[1] = 1'b0;
        idle(3);
        key_n_in[1] = 1'b1;
        idle(8);
        cycle(ADDR_KEY, 1'b1, 1'b0, 32'h0);
        chk("glitch_key", readdata, 32'h0);
        cycle(ADDR_EDGE, 1'b1, 1'b0, 32'h0);
        chk("glitch_edge", readdata, 32'h0);
        chk("glitch_irq", {31'h0, irq}, 32'h0);

        // Held press is accepted, captured and raises irq
        key_n_in[1] = 1'b0;
        idle(10);
        cycle(ADDR_KEY, 1'b1, 1'b0, 32'h0);
        chk("press_key", readdata, 32'h2);
        cycle(ADDR_EDGE, 1'b1, 1'b0, 32'h0);
        chk("press_edge", readdata, 32'h2);
        chk("press_irq", {31'h0, irq}, 32'h1);

        // W1C clear, then a clear landing on the same edge as a fresh capture
        cycle(ADDR_EDGE, 1'b0, 1'b1, 32'h2);
        idle(1);
        chk("w1c_irq", {31'h0, irq}, 32'h0);
        cycle(ADDR_EDGE, 1'b1, 1'b0, 32'h0);
        chk("w1c_edge", readdata, 32'h0);
        key_n_in[1] = 1'b1;
        idle(10);
        key_n_in[1] = 1'b0;
        idle(6);
        cycle(ADDR_EDGE, 1'b0, 1'b1, 32'h2);
        cycle(ADDR_EDGE, 1'b1, 1'b0, 32'h0);
        chk("set_wins", readdata, 32'h2);

        // Read and write the mask in one cycle
        cycle(ADDR_MASK, 1'b0, 1'b1, 32'h0);
        cycle(ADDR_MASK, 1'b1, 1'b1, 32'hF);
        chk("mask_rw_old", readdata, 32'h0);
        cycle(ADDR_MASK, 1'b1, 1'b0, 32'h0);
        chk("mask_rw_new", readdata, 32'hF);

        // Reset in the middle of a debounce run restarts the count
        key_n_in[2] = 1'b0;
        idle(4);
        do_reset();
        idle(5);
        cycle(ADDR_KEY, 1'b1, 1'b0, 32'h0);
        chk("restart_early", readdata, 32'h0);
        cycle(ADDR_KEY, 1'b1, 1'b0, 32'h0);
        chk("restart_done", readdata, 32'h6);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 9) == 0) key_n_in[k] = ~key_n_in[k];
            end
            if ($urandom_range(0, 15) == 0) sw_in = 10'($urandom);
            if ($urandom_range(0, 699) == 0) do_reset();
            cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
